// File: rtl/mat_mult_seq_ctrl.sv
// mat_mult_seq_ctrl: sequencer for the matrix-multiply datapath.
// Steps one product term per cycle through the A and B memories (k fastest,
// then col, then row), drives MAC clear/enable, and emits a C write strobe
// and address delayed by MAC_LAT so they line up with the MAC result.
// Optional macro: MMCTRL_STALL_EN adds a 'stall' input that freezes a
// running operation cycle-for-cycle.
module mat_mult_seq_ctrl #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int K       = 8,
  parameter int MAC_LAT = 2,
  parameter int CNT_W   = 16,
  localparam int AW = (ROWS * K    > 1) ? $clog2(ROWS * K)    : 1,
  localparam int BW = (K * COLS    > 1) ? $clog2(K * COLS)    : 1,
  localparam int CW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef MMCTRL_STALL_EN
  input  logic             stall,
`endif
  output logic [AW-1:0]    a_addr,
  output logic [BW-1:0]    b_addr,
  output logic             mac_en,
  output logic             mac_clr,
  output logic             c_we,
  output logic [CW-1:0]    c_addr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int KW  = (K > 1)    ? $clog2(K)    : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [RW-1:0]  row_reg, row_next;
  logic [CLW-1:0] col_reg, col_next;
  logic [KW-1:0]  k_reg, k_next;

  logic [AW-1:0]    a_addr_reg, a_addr_next;
  logic [BW-1:0]    b_addr_reg, b_addr_next;
  logic             mac_en_reg, mac_en_next;
  logic             mac_clr_reg, mac_clr_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [CNT_W-1:0] cycle_count_reg, cycle_count_next;

  logic stall_i;
  logic halt;
  logic last_term;
  logic issue_store;
  logic [CW-1:0] issue_addr;

  logic [MAC_LAT-1:0] dl_valid;
  logic [CW-1:0]      dl_addr [MAC_LAT];
  logic               dl_pending;

`ifdef MMCTRL_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  // A stall only matters while an operation is in flight
  assign halt = stall_i && ((state_reg == S_RUN) || (state_reg == S_DRAIN));

  assign last_term = (row_reg == RW'(ROWS - 1)) && (col_reg == CLW'(COLS - 1)) &&
                     (k_reg == KW'(K - 1));

  // The final term of a dot product schedules a C write MAC_LAT cycles later
  assign issue_store = (state_reg == S_RUN) && (k_reg == KW'(K - 1));
  assign issue_addr  = CW'(int'(row_reg) * COLS + int'(col_reg));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and term-counter logic
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    k_next     = k_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
          row_next   = '0;
          col_next   = '0;
          k_next     = '0;
        end
      end
      S_RUN: begin
        if (!halt) begin
          if (last_term) begin
            state_next = S_DRAIN;
          end else if (k_reg != KW'(K - 1)) begin
            k_next = k_reg + 1'b1;
          end else begin
            k_next = '0;
            if (col_reg != CLW'(COLS - 1)) begin
              col_next = col_reg + 1'b1;
            end else begin
              col_next = '0;
              row_next = row_reg + 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        // Leave once only the final stage (emitting now) can still be valid
        if (!halt && !dl_pending) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output next values, derived from where the sequencer will be next cycle
  always_comb begin
    a_addr_next  = AW'(int'(row_next) * K + int'(k_next));
    b_addr_next  = BW'(int'(k_next) * COLS + int'(col_next));
    mac_en_next  = (state_next == S_RUN);
    mac_clr_next = (state_next == S_RUN) && (k_next == '0);
    busy_next    = (state_next == S_RUN) || (state_next == S_DRAIN);
    done_next    = (state_next == S_DONE);
    cycle_count_next = cycle_count_reg;
    if ((state_reg == S_IDLE) && start) begin
      cycle_count_next = '0;
    end else if (((state_reg == S_RUN) || (state_reg == S_DRAIN)) && !halt &&
                 (cycle_count_reg != {CNT_W{1'b1}})) begin
      cycle_count_next = cycle_count_reg + 1'b1;
    end
  end

  // Counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      row_reg         <= '0;
      col_reg         <= '0;
      k_reg           <= '0;
      a_addr_reg      <= '0;
      b_addr_reg      <= '0;
      mac_en_reg      <= 1'b0;
      mac_clr_reg     <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      cycle_count_reg <= '0;
    end else begin
      row_reg         <= row_next;
      col_reg         <= col_next;
      k_reg           <= k_next;
      a_addr_reg      <= a_addr_next;
      b_addr_reg      <= b_addr_next;
      mac_en_reg      <= mac_en_next;
      mac_clr_reg     <= mac_clr_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      cycle_count_reg <= cycle_count_next;
    end
  end

  // Write-strobe delay line: one stage per cycle of MAC latency
  genvar gi;
  for (gi = 0; gi < MAC_LAT; gi++) begin : g_dl
    logic          valid_reg;
    logic [CW-1:0] addr_reg;
    logic          in_valid;
    logic [CW-1:0] in_addr;

    if (gi == 0) begin : g_head
      assign in_valid = issue_store;
      assign in_addr  = issue_addr;
    end else begin : g_tail
      assign in_valid = dl_valid[gi-1];
      assign in_addr  = dl_addr[gi-1];
    end

    // Advance one stage per unstalled cycle; empty slots carry address 0
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_reg <= 1'b0;
        addr_reg  <= '0;
      end else if (!halt) begin
        valid_reg <= in_valid;
        addr_reg  <= in_valid ? in_addr : '0;
      end
    end

    assign dl_valid[gi] = valid_reg;
    assign dl_addr[gi]  = addr_reg;
  end

  // Any valid entry short of the final stage means more writes are coming
  always_comb begin
    dl_pending = 1'b0;
    for (int j = 0; j < MAC_LAT - 1; j++) begin
      dl_pending = dl_pending | dl_valid[j];
    end
  end

  assign a_addr      = a_addr_reg;
  assign b_addr      = b_addr_reg;
  assign mac_en      = mac_en_reg & ~halt;
  assign mac_clr     = mac_clr_reg & ~halt;
  assign c_we        = dl_valid[MAC_LAT-1] & ~halt;
  assign c_addr      = dl_addr[MAC_LAT-1];
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_mat_mult_seq_ctrl.sv
// Bench for mat_mult_seq_ctrl: a default-size instance (4x4x8, latency 2)
// and a small instance (2x3x1, latency 1) run side by side. Expected outputs
// come from closed-form timing (term index, write index) driven by a
// phase/elapsed-cycle model, plus literal checks of the key timestamps.
module tb_mat_mult_seq_ctrl;

  localparam int R0 = 4, C0 = 4, K0 = 8, L0 = 2;
  localparam int R1 = 2, C1 = 3, K1 = 1, L1 = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stall_drv = 1'b0;

  logic [4:0]  a_addr0, b_addr0;
  logic [3:0]  c_addr0;
  logic        mac_en0, mac_clr0, c_we0, busy0, done0;
  logic [15:0] cnt0;

  logic [0:0]  a_addr1;
  logic [1:0]  b_addr1;
  logic [2:0]  c_addr1;
  logic        mac_en1, mac_clr1, c_we1, busy1, done1;
  logic [15:0] cnt1;

  always #5 clk = ~clk;

  mat_mult_seq_ctrl #(.ROWS(R0), .COLS(C0), .K(K0), .MAC_LAT(L0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .start(start),
`ifdef MMCTRL_STALL_EN
    .stall(stall_drv),
`endif
    .a_addr(a_addr0), .b_addr(b_addr0), .mac_en(mac_en0), .mac_clr(mac_clr0),
    .c_we(c_we0), .c_addr(c_addr0), .busy(busy0), .done(done0), .cycle_count(cnt0)
  );

  mat_mult_seq_ctrl #(.ROWS(R1), .COLS(C1), .K(K1), .MAC_LAT(L1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .start(start),
`ifdef MMCTRL_STALL_EN
    .stall(1'b0),
`endif
    .a_addr(a_addr1), .b_addr(b_addr1), .mac_en(mac_en1), .mac_clr(mac_clr1),
    .c_we(c_we1), .c_addr(c_addr1), .busy(busy1), .done(done1), .cycle_count(cnt1)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // model state per instance: phase 0 idle, 1 active (RUN/DRAIN), 2 done
  int m_phase [2] = '{0, 0};
  int m_e     [2] = '{0, 0};  // unstalled active cycles so far
  int m_t     [2] = '{0, 0};  // wall cycles since the run began
  int m_cnt   [2] = '{0, 0};
  bit m_ran   [2] = '{1'b0, 1'b0};

  // run statistics gathered by the compare process
  int rs_en = 0, rs_clr = 0, rs_we = 0, rs_t6 = -1, rs_done_t = -1;
  int a13 = -1, b13 = -1, en13 = -1, clr13 = -1;
  int rs1_we = 0, rs1_first = -1, rs1_last = -1, rs1_done_t = -1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int total(input int d);
    return (d == 0) ? R0 * C0 * K0 : R1 * C1 * K1;
  endfunction

  // Model: advance phase and elapsed counters on each clock edge
  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        bit s;
        int lat;
        s = (d == 0) ? stall_drv : 1'b0;
        lat = (d == 0) ? L0 : L1;
        if (reset) begin
          m_phase[d] = 0; m_e[d] = 0; m_t[d] = 0; m_cnt[d] = 0; m_ran[d] = 1'b0;
        end else if (m_phase[d] == 0) begin
          if (start) begin
            m_phase[d] = 1; m_e[d] = 0; m_t[d] = 0; m_cnt[d] = 0;
          end
        end else if (m_phase[d] == 1) begin
          m_t[d]++;
          if (!s) begin
            m_e[d]++;
            m_cnt[d] = m_e[d];
            if (m_e[d] == total(d) + lat) begin
              m_phase[d] = 2;
              m_ran[d] = 1'b1;
            end
          end
        end else if (!start) begin
          m_phase[d] = 0;
        end
      end
    end
  end

  task automatic check_dut(input int d, input int a, input int b, input int en,
                           input int clr, input int we, input int ca, input int bz,
                           input int dn, input int cnt);
    int R, C, KK, L, T, e, i, x;
    int ea, eb, een, eclr, ewe, eca, ebz, edn, ecnt;
    bit s, chk_addr;
    string p;
    R = (d == 0) ? R0 : R1; C = (d == 0) ? C0 : C1;
    KK = (d == 0) ? K0 : K1; L = (d == 0) ? L0 : L1;
    T = R * C * KK;
    s = (d == 0) ? stall_drv : 1'b0;
    p = $sformatf("d%0d", d);
    e = m_e[d];
    ea = 0; eb = 0; een = 0; eclr = 0; ewe = 0; eca = 0; ebz = 0; edn = 0;
    ecnt = m_cnt[d];
    chk_addr = 1'b0;
    if (m_phase[d] == 1) begin
      ebz = 1;
      ecnt = e;
      chk_addr = 1'b1;
      i = (e < T) ? e : T - 1;
      if (e < T && !s) begin
        een = 1;
        eclr = (i % KK == 0) ? 1 : 0;
      end
      ea = (i / (C * KK)) * KK + i % KK;
      eb = (i % KK) * C + (i / KK) % C;
      x = e - (KK - 1) - L;
      if (!s && x >= 0 && x % KK == 0 && x / KK < R * C) begin
        ewe = 1;
        eca = x / KK;
      end
    end else if (m_phase[d] == 2) begin
      edn = 1;
    end else if (!m_ran[d]) begin
      chk_addr = 1'b1;
    end
    chk({p, "_mac_en"}, en, een);
    chk({p, "_mac_clr"}, clr, eclr);
    chk({p, "_c_we"}, we, ewe);
    if (ewe == 1) chk({p, "_c_addr"}, ca, eca);
    chk({p, "_busy"}, bz, ebz);
    chk({p, "_done"}, dn, edn);
    chk({p, "_cycle_count"}, cnt, ecnt);
    if (chk_addr) begin
      chk({p, "_a_addr"}, a, ea);
      chk({p, "_b_addr"}, b, eb);
    end
  endtask

  // Compare process: check both instances mid-cycle and gather statistics
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check_dut(0, int'(a_addr0), int'(b_addr0), int'(mac_en0), int'(mac_clr0),
                  int'(c_we0), int'(c_addr0), int'(busy0), int'(done0), int'(cnt0));
        check_dut(1, int'(a_addr1), int'(b_addr1), int'(mac_en1), int'(mac_clr1),
                  int'(c_we1), int'(c_addr1), int'(busy1), int'(done1), int'(cnt1));
        if (mac_en0) rs_en++;
        if (mac_clr0) rs_clr++;
        if (c_we0) begin
          rs_we++;
          if (c_addr0 == 4'd6) rs_t6 = m_t[0];
        end
        if (done0 && rs_done_t < 0) rs_done_t = m_t[0];
        if (m_phase[0] == 1 && m_t[0] == 13) begin
          a13 = int'(a_addr0); b13 = int'(b_addr0); en13 = int'(mac_en0); clr13 = int'(mac_clr0);
        end
        if (c_we1) begin
          rs1_we++;
          if (rs1_first < 0) rs1_first = m_t[1];
          rs1_last = m_t[1];
        end
        if (done1 && rs1_done_t < 0) rs1_done_t = m_t[1];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_stats();
    rs_en = 0; rs_clr = 0; rs_we = 0; rs_t6 = -1; rs_done_t = -1;
    a13 = -1; b13 = -1; en13 = -1; clr13 = -1;
    rs1_we = 0; rs1_first = -1; rs1_last = -1; rs1_done_t = -1;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done0 && n < 400) begin
      tick();
      n++;
    end
    chk({nm, "_done_timeout"}, int'(done0), 1);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_t(input int t, input string nm);
    int n;
    n = 0;
    while (m_t[0] != t && n < 400) begin
      tick();
      n++;
    end
    chk({nm, "_reach_t"}, m_t[0], t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset_cycle_count", int'(cnt0), 0);
    chk("reset_busy", int'(busy0), 0);

    // run 1: single-cycle start pulse on both instances
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("run1");
    chk("run1_mac_en_cycles", rs_en, 128);
    chk("run1_mac_clr_cycles", rs_clr, 16);
    chk("run1_c_we_pulses", rs_we, 16);
    chk("run1_c_we_n6_t", rs_t6, 57);
    chk("run1_done_t", rs_done_t, 130);
    chk("run1_cycle_count", int'(cnt0), 130);
    chk("t13_a_addr", a13, 5);
    chk("t13_b_addr", b13, 21);
    chk("t13_mac_en", en13, 1);
    chk("t13_mac_clr", clr13, 0);
    chk("small_c_we_pulses", rs1_we, 6);
    chk("small_first_c_we_t", rs1_first, 1);
    chk("small_last_c_we_t", rs1_last, 6);
    chk("small_done_t", rs1_done_t, 7);
    tick();

    // run 2: start held high through DONE, then dropped and re-raised
    clear_stats();
    start = 1'b1;
    tick();
    wait_done("hold");
    clear_stats();
    repeat (20) tick();
    chk("hold_mac_en_cycles", rs_en, 0);
    chk("hold_done", int'(done0), 1);
    chk("hold_busy", int'(busy0), 0);
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("rerun");
    chk("rerun_cycle_count", int'(cnt0), 130);
    chk("rerun_mac_en_cycles", rs_en, 128);
    tick();

    // run 3: reset asserted in cycle t=60
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_t(60, "rst");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_a_addr", int'(a_addr0), 0);
    chk("rst_b_addr", int'(b_addr0), 0);
    chk("rst_mac_en", int'(mac_en0), 0);
    chk("rst_c_we", int'(c_we0), 0);
    chk("rst_c_addr", int'(c_addr0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_cycle_count", int'(cnt0), 0);
    clear_stats();
    repeat (10) tick();
    chk("rst_c_we_after", rs_we, 0);

`ifdef MMCTRL_STALL_EN
    // run 4: stall for t=50..54
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_t(50, "stall");
    stall_drv = 1'b1;
    repeat (5) tick();
    stall_drv = 1'b0;
    wait_done("stall");
    chk("stall_c_we_n6_t", rs_t6, 62);
    chk("stall_done_t", rs_done_t, 135);
    chk("stall_cycle_count", int'(cnt0), 130);
    chk("stall_mac_en_cycles", rs_en, 128);
    chk("stall_c_we_pulses", rs_we, 16);
    tick();
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_mult_seq_ctrl.md
# mat_mult_seq_ctrl

Parametrised sequencer for the matrix-multiply datapath. It computes C[ROWS×COLS] = A[ROWS×K] · B[K×COLS] by stepping one product term per cycle through A and B memory addresses. It drives accumulator clear and enable to the MAC, and issues a delayed C write strobe and address that track the MAC pipeline latency. It replaces the fixed 8-term, hard-coded-count controller with configurable dimensions, explicit address generation, pipeline drain and cycle accounting.

## Interface
Parameters:
- ROWS, 4, rows of A and C (≥1)
- COLS, 4, columns of B and C (≥1)
- K, 8, inner dimension, i.e. terms per dot product (≥1)
- MAC_LAT, 2, cycles from a term's issue to the MAC result being valid (≥1)
- CNT_W, 16, width of cycle_count

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset
- start  in  1  level request; sampled in IDLE and DONE
- a_addr  out  max(1,$clog2(ROWS*K))  A read address = row*K + k
- b_addr  out  max(1,$clog2(K*COLS))  B read address = k*COLS + col
- mac_en  out  1  MAC consumes a term this cycle
- mac_clr  out  1  with mac_en: acc ← product instead of acc + product (first term, k==0)
- c_we  out  1  write MAC result to C
- c_addr  out  max(1,$clog2(ROWS*COLS))  C write address = row*COLS + col
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- cycle_count  out  CNT_W  RUN+DRAIN cycles of the current/last operation

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to IDLE; counters and delay line are cleared.
- IDLE: when start=1, go to RUN. On that edge, k, col, row and cycle_count clear to 0.
- RUN: each cycle issues one term (row, col, k), with mac_en=1 and mac_clr=(k==0).
  - Loop order: k fastest, then col, then row.
  - When the term with row=ROWS-1, col=COLS-1, k=K-1 is issued, go to DRAIN.
- Delay line: MAC_LAT stages carry {valid, c_addr}. A stage is loaded valid when the issued term has k==K-1. c_we and c_addr come from the last stage.
- DRAIN: mac_en=0, addresses hold. Stay here until the delay line is empty, then go to DONE.
- DONE: done=1, cycle_count holds. When start=0, go to IDLE. If start is still 1, stay in DONE (no auto-restart).
- start is ignored in RUN and DRAIN.
- cycle_count increments in every RUN and DRAIN cycle. It saturates at 2^CNT_W-1.
- reset asserted mid-operation: the next cycle is IDLE with all outputs 0. In-flight delay-line entries are discarded and no c_we is emitted.

## Timing
- T = ROWS*COLS*K. t=0 is the first RUN cycle, i.e. the cycle after the edge that samples start=1 in IDLE.
- Term index i = (row*COLS+col)*K + k is presented in cycle t=i.
- Output n = row*COLS+col: c_we=1 with c_addr=n in cycle t = n*K + K-1 + MAC_LAT. This is exactly one pulse per output, in ascending n.
- RUN spans t=0..T-1 and DRAIN spans t=T..T+MAC_LAT-1. The last c_we falls in the final DRAIN cycle.
- DONE starts at t = T+MAC_LAT, with cycle_count = T+MAC_LAT.
- K=1: mac_clr=1 on every term, and c_we occurs every cycle once the pipeline is filled.
- Minimum re-run gap: start must be low for at least one cycle in DONE, then IDLE accepts start one cycle later.

## Configuration
- MMCTRL_STALL_EN defined: adds input stall (1 bit).
  - When stall=1 in RUN or DRAIN, the k/col/row counters, delay line, state and cycle_count freeze.
  - mac_en=0 and c_we=0 in that cycle; addresses hold.
  - The operation resumes exactly where it stopped, and stalled cycles are not counted.
  - stall has no effect in IDLE or DONE.
- MMCTRL_STALL_EN undefined: no stall port exists, and behaviour is identical to stall tied to 0.

## Test plan
- Defaults, pulse start for 1 cycle: 128 mac_en cycles; mac_clr at t=0,8,…,120; 16 c_we pulses at t=9,17,…,129 with c_addr 0..15; done at t=130 with cycle_count=130.
- Address check at t=13 (row0, col1, k5): a_addr=5, b_addr=21, mac_en=1, mac_clr=0.
- Hold start=1 through DONE for 20 cycles: no restart. Drop start, raise it 2 cycles later: second run's cycle_count=130.
- Assert reset at t=60: next cycle all outputs 0, state IDLE, and no c_we follows for 10 cycles.
- ROWS=2, COLS=3, K=1, MAC_LAT=1: c_we at t=1..6 with c_addr 0..5; done at t=7.
- With MMCTRL_STALL_EN, stall high for t=50..54: mac_en and c_we low in those cycles; c_we for n=6 moves from t=57 to t=62; done arrives 5 cycles late with cycle_count=130.
